// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the 8-bit ALU: fetch one instruction over valid/ready,
// read a 4 x 8 register file, drive the external ALU, then write back or emit via OUT.
//
// state  | meaning
// IDLE   | ready for an instruction, captures instr into ir on handshake
// DECODE | reads operands from the register file into the operand latches
// EXEC   | presents latched operands to the ALU, registers alu_result
// WB     | retires: register/zero_flag write or OUT pulse
module alu_seq_ctrl #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] REG_INIT = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [7:0]        instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              zero_flag,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  state_t            state, state_nxt;
  logic [7:0]        ir;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] op_a, op_b, result_q;
  logic [1:0]        opcode, rd, rs;

  assign opcode = ir[7:6];
  assign rd     = ir[5:4];
  assign rs     = ir[3:2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      result_q  <= '0;
      zero_flag <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= REG_INIT;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (instr_valid) ir <= instr;
        DECODE: begin
          case (opcode)
            OP_ADD, OP_SUB: begin op_a <= regs[rd]; op_b <= regs[rs]; end
            OP_LDI: begin op_a <= '0; op_b <= {{(DATA_W-4){1'b0}}, ir[3:0]}; end
            default: begin op_a <= regs[rd]; op_b <= '0; end
          endcase
        end
        EXEC: begin
          result_q <= alu_result;
          // out_data is loaded one cycle early so it is already valid during WB and then holds
          if (opcode == OP_OUT) out_data <= alu_result;
        end
        WB: begin
          if (opcode != OP_OUT) begin
            regs[rd]  <= result_q;
            zero_flag <= (result_q == '0);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    busy        = (state != IDLE);
    done        = 1'b0;
    out_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_sel     = 3'b111;
    case (state)
      IDLE: begin
        instr_ready = rst_n;
        if (instr_valid) state_nxt = DECODE;
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        state_nxt = WB;
        alu_a     = op_a;
        alu_b     = op_b;
        alu_sel   = (opcode == OP_SUB) ? 3'b001 : 3'b000;
      end
      WB: begin
        state_nxt = IDLE;
        done      = 1'b1;
        out_valid = (opcode == OP_OUT);
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: an instruction-level model predicts every output each cycle,
// and directed programs pin known results with literal values before a random soak.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instr_ready, out_valid, zero_flag, done, busy;
  logic [7:0] alu_a, alu_b, alu_result, out_data;
  logic [2:0] alu_sel;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DATA_W(8), .REG_INIT(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .out_valid(out_valid), .out_data(out_data),
    .zero_flag(zero_flag), .done(done), .busy(busy)
  );

  // external ALU
  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: an accepted instruction is fully evaluated at once,
  // then its visible effects are released at the cycle positions they must appear.
  logic [7:0] m_reg [4];
  int         m_cyc;            // cycles since acceptance, 0 = idle
  logic [7:0] m_ins, m_a, m_b, m_res, m_out;
  logic [2:0] m_sel;
  logic       m_zf;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_cyc = 0; m_ins = 0; m_a = 0; m_b = 0; m_res = 0; m_sel = 3'b111;
      m_zf = 0; m_out = 0;
    end else if (m_cyc == 0) begin
      if (instr_valid) begin
        m_ins = instr;
        case (instr[7:6])
          2'd0: begin m_a = m_reg[instr[5:4]]; m_b = m_reg[instr[3:2]]; m_sel = 3'b000;
                      m_res = 8'((int'(m_a) + int'(m_b)) % 256); end
          2'd1: begin m_a = m_reg[instr[5:4]]; m_b = m_reg[instr[3:2]]; m_sel = 3'b001;
                      m_res = 8'((int'(m_a) - int'(m_b) + 256) % 256); end
          2'd2: begin m_a = 0; m_b = {4'h0, instr[3:0]}; m_sel = 3'b000; m_res = m_b; end
          default: begin m_a = m_reg[instr[5:4]]; m_b = 0; m_sel = 3'b000; m_res = m_a; end
        endcase
        m_cyc = 1;
      end
    end else if (m_cyc == 3) begin
      if (m_ins[7:6] != 2'd3) begin
        m_reg[m_ins[5:4]] = m_res;
        m_zf = (m_res == 0);
      end
      m_cyc = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (m_cyc == 3 && m_ins[7:6] == 2'd3) m_out = m_res;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("instr_ready", instr_ready, rst_n && m_cyc == 0);
      check("busy",        busy,        m_cyc != 0);
      check("done",        done,        m_cyc == 3);
      check("out_valid",   out_valid,   m_cyc == 3 && m_ins[7:6] == 2'd3);
      check("out_data",    out_data,    m_out);
      check("zero_flag",   zero_flag,   m_zf);
      check("alu_a",       alu_a,       (m_cyc == 2) ? m_a : 8'h00);
      check("alu_b",       alu_b,       (m_cyc == 2) ? m_b : 8'h00);
      check("alu_sel",     alu_sel,     (m_cyc == 2) ? m_sel : 3'b111);
    end
  end

  // Issue one instruction and wait for it to retire; returns what appeared in WB.
  task automatic issue(input logic [7:0] w, output logic [7:0] od, output logic ov, output int lat);
    int n = 0;
    instr_valid = 1'b1; instr = w; od = 0; ov = 0;
    while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 8'($urandom);
    lat = 1;
    while (!done && lat < 10) begin @(posedge clk); #1; lat++; end
    if (!done) check("retire_timeout", 0, 1);
    od = out_data; ov = out_valid;
    @(posedge clk); #1;
  endtask

  logic [7:0] od;
  logic       ov;
  int         lat;
  logic [7:0] dbl [5] = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0};

  initial begin
    @(posedge clk); #1;
    check("reset_ready_low", instr_ready, 0);
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_out_data", out_data, 0);
    rst_n = 1'b1;

    issue(8'h95, od, ov, lat);              // LDI R1,#5
    check("ldi_latency", lat, 3);
    check("ldi_zf", zero_flag, 0);
    check("ldi_ready_back", instr_ready, 1);
    issue(8'hA3, od, ov, lat);              // LDI R2,#3
    issue(8'h18, od, ov, lat);              // ADD R1,R2
    issue(8'hD0, od, ov, lat);              // OUT R1
    check("out_r1_valid", ov, 1);
    check("out_r1", od, 8'h08);
    issue(8'hE0, od, ov, lat);              // OUT R2
    check("out_r2", od, 8'h03);
    issue(8'h6A, od, ov, lat);              // SUB R2,R2
    check("sub_zero_zf", zero_flag, 1);
    issue(8'h64, od, ov, lat);              // SUB R2,R1
    check("sub_wrap_zf", zero_flag, 0);
    issue(8'hE0, od, ov, lat);
    check("sub_wrap_val", od, 8'hF8);

    issue(8'hBF, od, ov, lat);              // LDI R3,#15
    for (int i = 0; i < 5; i++) begin
      issue(8'h3C, od, ov, lat);            // ADD R3,R3
      issue(8'hF0, od, ov, lat);            // OUT R3
      check("double_r3", od, dbl[i]);
    end

    // instr_valid held across a whole instruction with a different word waiting
    instr_valid = 1'b1; instr = 8'h95;
    @(posedge clk); #1;
    instr = 8'hD0;
    repeat (3) begin
      check("hold_ready_low", instr_ready, 0);
      @(posedge clk); #1;
    end
    check("hold_accept_ready", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("hold_out_valid", out_valid, 1);
    check("hold_out_r1", out_data, 8'h05);
    @(posedge clk); #1;

    // reset during EXEC of ADD R0,R1
    issue(8'h81, od, ov, lat);              // LDI R0,#1
    instr_valid = 1'b1; instr = 8'h04;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_exec_sel", alu_sel, 3'b000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_zf", zero_flag, 0);
    issue(8'hC0, od, ov, lat);              // OUT R0
    check("abort_r0_init", od, 8'h00);
    issue(8'h89, od, ov, lat);              // LDI R0,#9
    issue(8'hC0, od, ov, lat);
    check("resume_r0", od, 8'h09);

    // random soak, including held valid, gaps and occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst_n       = ($urandom_range(0, 80) != 0);
      instr_valid = ($urandom_range(0, 2) != 0);
      instr       = 8'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; instr_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
